// File: rtl/keypad_conditioner.sv
// Keypad input conditioner: 2-FF synchronisers, press/release debounce FSM, enter strobe, digit latch, press counter.
// Optional build macro DIGIT_DEBOUNCE_EN additionally requires the digit switches to be stable before a press confirms.
module keypad_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic [3:0] digit_raw,
  output logic       enter_pulse,
  output logic [3:0] digit_out,
  output logic       btn_held,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             btn_m_q, btn_s_q;
  logic [3:0]       digit_m_q, digit_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enter_pulse_q, enter_pulse_d;
  logic [3:0]       digit_out_q, digit_out_d;
  logic [7:0]       press_count_q, press_count_d;
  logic             digit_stable;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v < CNT_MAX) ? v + CNT_W'(1) : v;
  endfunction

  // Two-stage synchronisers for the asynchronous pins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_m_q   <= 1'b0;
      btn_s_q   <= 1'b0;
      digit_m_q <= 4'd0;
      digit_s_q <= 4'd0;
    end else begin
      btn_m_q   <= btn_raw;
      btn_s_q   <= btn_m_q;
      digit_m_q <= digit_raw;
      digit_s_q <= digit_m_q;
    end
  end

`ifdef DIGIT_DEBOUNCE_EN
  logic [3:0]       digit_prev_q;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;

  // Run length of the synced digit; restarts at 1 whenever it changes
  always_comb begin
    dcnt_d = sat_inc(dcnt_q);
    if (digit_s_q != digit_prev_q) begin
      dcnt_d = CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_prev_q <= 4'd0;
      dcnt_q       <= '0;
    end else begin
      digit_prev_q <= digit_s_q;
      dcnt_q       <= dcnt_d;
    end
  end

  assign digit_stable = (dcnt_q >= CNT_MAX);
`else
  assign digit_stable = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    enter_pulse_d = 1'b0;
    digit_out_d   = digit_out_q;
    press_count_d = press_count_q;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = PRESS_DEB;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_DEB: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if ((cnt_q >= CNT_LAST) && digit_stable) begin
          // cnt may sit saturated here while waiting for a stable digit
          state_d       = HELD;
          cnt_d         = '0;
          enter_pulse_d = 1'b1;
          digit_out_d   = digit_s_q;
          press_count_d = press_count_q + 8'd1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = REL_DEB;
          cnt_d   = CNT_W'(1);
        end
      end
      REL_DEB: begin
        if (btn_s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      enter_pulse_q <= 1'b0;
      digit_out_q   <= 4'd0;
      press_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      enter_pulse_q <= enter_pulse_d;
      digit_out_q   <= digit_out_d;
      press_count_q <= press_count_d;
    end
  end

  assign enter_pulse = enter_pulse_q;
  assign digit_out   = digit_out_q;
  assign press_count = press_count_q;
  assign btn_held    = (state_q == HELD) || (state_q == REL_DEB);

endmodule
